// File: rtl/hdc_encode_seq_if.sv
// Handshake and data bundle between the HDC encoding sequencer and its
// surroundings: sample control, feature stream, generator control/response,
// and the bundled-hypervector output stream.
// The master side drives sample control, features and generator responses.
// The slave side is the sequencer itself.
interface hdc_encode_seq_if #(
    parameter int D      = 2048,
    parameter int CNT_W  = 8,
    parameter int FEAT_W = 10
);
    // sample control
    logic              start;
    logic [FEAT_W-1:0] num_feat;
    logic [CNT_W-1:0]  threshold;
    logic [10:0]       seed_base;
    logic              busy;
    logic              err;

    // feature stream
    logic              feat_valid;
    logic              feat_ready;
    logic [12:0]       feat_level;

    // generator control and response
    logic              gen_req;
    logic [10:0]       gen_seed;
    logic [12:0]       gen_scalar;
    logic              hv_valid;
    logic [D-1:0]      pos_hv;
    logic [D-1:0]      lvl_hv;

    // bundled output stream
    logic              out_valid;
    logic              out_ready;
    logic [D-1:0]      bundled_hv;

    modport master (
        output start, num_feat, threshold, seed_base,
        output feat_valid, feat_level,
        output hv_valid, pos_hv, lvl_hv,
        output out_ready,
        input  feat_ready, gen_req, gen_seed, gen_scalar,
        input  out_valid, bundled_hv, busy, err
    );

    modport slave (
        input  start, num_feat, threshold, seed_base,
        input  feat_valid, feat_level,
        input  hv_valid, pos_hv, lvl_hv,
        input  out_ready,
        output feat_ready, gen_req, gen_seed, gen_scalar,
        output out_valid, bundled_hv, busy, err
    );
endinterface

// File: rtl/hdc_encode_seq.sv
// HDC encoding sequencer. For each feature of a sample it hands a seed and
// scalar to the position/level generators, binds their outputs by XOR,
// accumulates the bound vector into per-bit saturating counters, and finally
// thresholds the counters into the bundled hypervector.
module hdc_encode_seq #(
    parameter int D       = 2048,
    parameter int CNT_W   = 8,
    parameter int FEAT_W  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    hdc_encode_seq_if.slave bus
);

    localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMO_LIMIT = TMR_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_REQ,
        S_WAIT,
        S_ACC,
        S_THRESH,
        S_OUT
    } state_t;

    state_t            state;
    logic [FEAT_W-1:0] nf_q;
    logic [FEAT_W-1:0] k;
    logic [FEAT_W:0]   k_next;
    logic [CNT_W-1:0]  thr_q;
    logic [10:0]       seed_base_q;
    logic [TMR_W-1:0]  timer;
    logic [CNT_W-1:0]  cnt [D];
    logic [D-1:0]      xored;

    logic              feat_ready_q;
    logic              gen_req_q;
    logic [10:0]       gen_seed_q;
    logic [12:0]       gen_scalar_q;
    logic              out_valid_q;
    logic [D-1:0]      bundled_q;
    logic              busy_q;
    logic              err_q;

    // Add one bound bit to a bundling counter, sticking at the top value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                  input logic b);
        logic [CNT_W-1:0] r;
        if (b && (c != CNT_MAX)) r = c + 1'b1;
        else                     r = c;
        return r;
    endfunction

    // Per-feature LFSR seed; an all-zero seed would lock the LFSR, so it is
    // replaced by 1.
    function automatic logic [10:0] feat_seed(input logic [10:0]       base,
                                              input logic [FEAT_W-1:0] idx);
        logic [10:0] s;
        s = base + 11'(idx);
        if (s == 11'd0) s = 11'h001;
        return s;
    endfunction

    assign k_next = {1'b0, k} + 1'b1;

    // Bound vector capture; qualified by state so it needs no reset.
    always_ff @(posedge clk) begin
        if ((state == S_WAIT) && bus.hv_valid) begin
            xored <= bus.pos_hv ^ bus.lvl_hv;
        end
    end

    // Sequencer FSM with registered handshake outputs and counter bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            nf_q         <= '0;
            k            <= '0;
            thr_q        <= '0;
            seed_base_q  <= '0;
            timer        <= '0;
            feat_ready_q <= 1'b0;
            gen_req_q    <= 1'b0;
            gen_seed_q   <= '0;
            gen_scalar_q <= '0;
            out_valid_q  <= 1'b0;
            bundled_q    <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < D; i++) cnt[i] <= '0;
        end else begin
            gen_req_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        nf_q        <= bus.num_feat;
                        thr_q       <= bus.threshold;
                        seed_base_q <= bus.seed_base;
                        k           <= '0;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        for (int i = 0; i < D; i++) cnt[i] <= '0;
                        if (bus.num_feat == '0) begin
                            state <= S_THRESH;
                        end else begin
                            state        <= S_FETCH;
                            feat_ready_q <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    if (bus.feat_valid) begin
                        gen_scalar_q <= bus.feat_level;
                        gen_seed_q   <= feat_seed(seed_base_q, k);
                        feat_ready_q <= 1'b0;
                        gen_req_q    <= 1'b1;
                        state        <= S_REQ;
                    end
                end

                S_REQ: begin
                    timer <= '0;
                    state <= S_WAIT;
                end

                // A response in the same cycle the limit is reached still wins.
                S_WAIT: begin
                    if (bus.hv_valid) begin
                        state <= S_ACC;
                    end else if (timer >= TMO_LIMIT) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_ACC: begin
                    for (int i = 0; i < D; i++) cnt[i] <= sat_inc(cnt[i], xored[i]);
                    k <= k_next[FEAT_W-1:0];
                    if (k_next == {1'b0, nf_q}) begin
                        state <= S_THRESH;
                    end else begin
                        state        <= S_FETCH;
                        feat_ready_q <= 1'b1;
                    end
                end

                S_THRESH: begin
                    for (int i = 0; i < D; i++) bundled_q[i] <= (cnt[i] >= thr_q);
                    out_valid_q <= 1'b1;
                    state       <= S_OUT;
                end

                // bundled_q is only written in THRESH, so it holds under backpressure
                // and after hand-off.
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    feat_ready_q <= 1'b0;
                    out_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.feat_ready = feat_ready_q;
    assign bus.gen_req    = gen_req_q;
    assign bus.gen_seed   = gen_seed_q;
    assign bus.gen_scalar = gen_scalar_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.bundled_hv = bundled_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_hdc_encode_seq.sv
// Directed bench for hdc_encode_seq with a small configuration (D=8, CNT_W=2)
// so that saturation and timeout are reachable in a few cycles.
module tb_hdc_encode_seq;
    localparam int D       = 8;
    localparam int CNT_W   = 2;
    localparam int FEAT_W  = 10;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdc_encode_seq_if #(.D(D), .CNT_W(CNT_W), .FEAT_W(FEAT_W)) bus();

    hdc_encode_seq #(.D(D), .CNT_W(CNT_W), .FEAT_W(FEAT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  pats    [0:7];
    logic [10:0] seeds   [0:7];
    logic [12:0] scalars [0:7];
    int          lat;
    int          nreq;
    int          acc_cyc;
    logic [7:0]  res;
    bit          unstable;
    logic        post_ov;
    logic        post_busy;

    task automatic idle_inputs();
        bus.start = 0; bus.num_feat = '0; bus.threshold = '0; bus.seed_base = '0;
        bus.feat_valid = 0; bus.feat_level = '0;
        bus.hv_valid = 0; bus.pos_hv = '0; bus.lvl_hv = '0;
        bus.out_ready = 0;
    endtask

    // Drives one sample: features always offered, generator answering the
    // cycle after gen_req when respond=1, consumer ready 'hold' cycles after
    // out_valid rises. Latency is counted in edges from the start edge (1).
    task automatic run_sample(input int nf, input int thr, input int sb,
                              input int hold, input bit respond);
        bit hv_pend;
        bit acc_pend;
        bit finished;
        logic [7:0] held;
        lat = -1; nreq = 0; acc_cyc = -1; unstable = 0;
        hv_pend = 0; acc_pend = 0; finished = 0; held = '0;
        post_ov = 1'bx; post_busy = 1'bx;
        @(negedge clk);
        bus.start = 1; bus.num_feat = nf[FEAT_W-1:0];
        bus.threshold = thr[CNT_W-1:0]; bus.seed_base = sb[10:0];
        bus.feat_valid = 1; bus.feat_level = 13'h100;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.start = 0; bus.num_feat = 10'd7;
                bus.threshold = ~bus.threshold; bus.seed_base = 11'h555;
            end
            if (cyc == 3 && nf > 0) bus.start = 1;
            if (cyc == 4) bus.start = 0;
            if (acc_pend) begin
                post_ov = bus.out_valid; post_busy = bus.busy; acc_cyc = cyc;
                finished = 1;
                break;
            end
            bus.hv_valid = hv_pend;
            if (hv_pend) begin
                bus.lvl_hv = 8'hA5 ^ 8'(nreq * 17);
                bus.pos_hv = pats[nreq-1] ^ bus.lvl_hv;
            end
            hv_pend = 0;
            if (bus.gen_req) begin
                if (nreq < 8) begin seeds[nreq] = bus.gen_seed; scalars[nreq] = bus.gen_scalar; end
                nreq++;
                bus.feat_level = 13'h100 + 13'(nreq);
                hv_pend = respond;
            end
            if (bus.out_valid) begin
                if (lat < 0) begin lat = cyc; held = bus.bundled_hv; end
                else if (bus.bundled_hv !== held) unstable = 1;
                if (cyc - lat >= hold) begin bus.out_ready = 1; acc_pend = 1; end
            end
            if (cyc > 1 && !bus.busy && lat < 0) begin
                finished = 1;
                break;
            end
        end
        bus.hv_valid = 0; bus.out_ready = 0; bus.feat_valid = 0;
        res = held;
        checks++; if (!finished) begin errors++; $display("FAIL sample_done got timeout want completion within 400 cycles"); end
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst = 0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.feat_ready !== 1'b0) begin errors++; $display("FAIL reset_feat_ready got %b want 0", bus.feat_ready); end
        checks++; if (bus.gen_req !== 1'b0) begin errors++; $display("FAIL reset_gen_req got %b want 0", bus.gen_req); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
        checks++; if (bus.bundled_hv !== 8'h00) begin errors++; $display("FAIL reset_bundled got %h want 00", bus.bundled_hv); end
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pats[0] = 8'h0F; pats[1] = 8'h3C; pats[2] = 8'hF0;
        run_sample(3, 2, 11'h123, 0, 1'b1);
        checks++; if (lat !== 14) begin errors++; $display("FAIL basic_latency got %0d want 14", lat); end
        checks++; if (res !== 8'h3C) begin errors++; $display("FAIL basic_bundled got %h want 3c", res); end
        checks++; if (nreq !== 3) begin errors++; $display("FAIL basic_req_count got %0d want 3", nreq); end
        checks++; if (seeds[0] !== 11'h123) begin errors++; $display("FAIL basic_seed0 got %h want 123", seeds[0]); end
        checks++; if (seeds[1] !== 11'h124) begin errors++; $display("FAIL basic_seed1 got %h want 124", seeds[1]); end
        checks++; if (seeds[2] !== 11'h125) begin errors++; $display("FAIL basic_seed2 got %h want 125", seeds[2]); end
        checks++; if (scalars[0] !== 13'h100) begin errors++; $display("FAIL basic_scalar0 got %h want 100", scalars[0]); end
        checks++; if (scalars[2] !== 13'h102) begin errors++; $display("FAIL basic_scalar2 got %h want 102", scalars[2]); end
        checks++; if (post_ov !== 1'b0) begin errors++; $display("FAIL basic_ov_after_accept got %b want 0", post_ov); end
        checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after_accept got %b want 0", post_busy); end
        checks++; if (bus.bundled_hv !== 8'h3C) begin errors++; $display("FAIL basic_bundled_kept got %h want 3c", bus.bundled_hv); end
    endtask

    task automatic test_seed_wrap();
        pats[0] = 8'h01; pats[1] = 8'h02;
        run_sample(2, 1, 11'h7FF, 0, 1'b1);
        checks++; if (seeds[0] !== 11'h7FF) begin errors++; $display("FAIL wrap_seed0 got %h want 7ff", seeds[0]); end
        checks++; if (seeds[1] !== 11'h001) begin errors++; $display("FAIL wrap_seed1 got %h want 001", seeds[1]); end
        checks++; if (res !== 8'h03) begin errors++; $display("FAIL wrap_bundled got %h want 03", res); end
    endtask

    task automatic test_zero_feat();
        run_sample(0, 0, 11'h040, 0, 1'b1);
        checks++; if (nreq !== 0) begin errors++; $display("FAIL zero_req_count got %0d want 0", nreq); end
        checks++; if (res !== 8'hFF) begin errors++; $display("FAIL zero_bundled got %h want ff", res); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency got %0d want 2", lat); end
    endtask

    task automatic test_saturate();
        pats[0] = 8'hFF; pats[1] = 8'hFF; pats[2] = 8'hFE; pats[3] = 8'hFE; pats[4] = 8'hFE;
        run_sample(5, 3, 11'h200, 0, 1'b1);
        checks++; if (res !== 8'hFE) begin errors++; $display("FAIL sat_bundled got %h want fe", res); end
        checks++; if (lat !== 22) begin errors++; $display("FAIL sat_latency got %0d want 22", lat); end
    endtask

    task automatic test_timeout();
        run_sample(2, 1, 11'h010, 0, 1'b0);
        checks++; if (lat !== -1) begin errors++; $display("FAIL tmo_out_valid got lat %0d want never", lat); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b want 0", bus.busy); end
        checks++; if (nreq !== 1) begin errors++; $display("FAIL tmo_req_count got %0d want 1", nreq); end
        pats[0] = 8'h81; pats[1] = 8'h18;
        run_sample(2, 1, 11'h010, 0, 1'b1);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL tmo_err_cleared got %b want 0", bus.err); end
        checks++; if (res !== 8'h99) begin errors++; $display("FAIL tmo_next_bundled got %h want 99", res); end
    endtask

    task automatic test_backpressure();
        pats[0] = 8'hAA; pats[1] = 8'hCC; pats[2] = 8'hF0;
        run_sample(3, 2, 11'h300, 10, 1'b1);
        checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL bp_stable got %b want 0", unstable); end
        checks++; if (res !== 8'hE8) begin errors++; $display("FAIL bp_bundled got %h want e8", res); end
        checks++; if (acc_cyc !== lat + 11) begin errors++; $display("FAIL bp_accept_cycle got %0d want %0d", acc_cyc, lat + 11); end
        checks++; if (post_ov !== 1'b0) begin errors++; $display("FAIL bp_ov_after_accept got %b want 0", post_ov); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        @(negedge clk);
        bus.start = 1; bus.num_feat = 10'd3; bus.threshold = 2'd1; bus.seed_base = 11'h0AB;
        bus.feat_valid = 1; bus.feat_level = 13'h1234;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = 0;
            if (bus.gen_req) begin seen = 1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rmid_gen_req got none want pulse within 20 cycles"); end
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
        checks++; if (bus.bundled_hv !== 8'h00) begin errors++; $display("FAIL rmid_bundled got %h want 00", bus.bundled_hv); end
        checks++; if (bus.gen_seed !== 11'h000) begin errors++; $display("FAIL rmid_gen_seed got %h want 000", bus.gen_seed); end
        checks++; if (bus.gen_scalar !== 13'h0000) begin errors++; $display("FAIL rmid_gen_scalar got %h want 0000", bus.gen_scalar); end
        checks++; if ({bus.out_valid, bus.feat_ready, bus.gen_req, bus.err} !== 4'b0000) begin
            errors++; $display("FAIL rmid_ctrl got %b want 0000", {bus.out_valid, bus.feat_ready, bus.gen_req, bus.err});
        end
        idle_inputs();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seed_wrap();
        test_zero_feat();
        test_saturate();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdc_encode_seq.md
Name: hdc_encode_seq

Overview:
- Sequencer for the HDC encoding datapath: the LFSR position-HV generator, the random-flip level-HV generator and XOR binding.
- Accepts a stream of per-feature levels and configures the generators with seed/scalar for each feature.
- Collects each bound hypervector, accumulates it into per-bit saturating counters, then thresholds the counters into the bundled hypervector.
- Sits between the feature front end and the classifier/associative memory.

Parameters:
D, 2048, hypervector dimension
CNT_W, 8, per-bit bundling counter width (saturating)
FEAT_W, 10, width of feature count
TIMEOUT, 255, max cycles to wait for generator response

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin encoding a sample; sampled only in IDLE
num_feat  input  FEAT_W  features per sample; latched on start
threshold  input  CNT_W  bundling threshold; latched on start
seed_base  input  11  base LFSR seed; latched on start
feat_valid  input  1  feature level available
feat_ready  output  1  feature level accepted when valid&ready
feat_level  input  13  feature level, used as LFSR scalar
gen_req  output  1  one-cycle pulse: load seed/scalar and generate
gen_seed  output  11  seed for current feature
gen_scalar  output  13  scalar for current feature
hv_valid  input  1  generator outputs valid, sampled in WAIT only
pos_hv  input  D  position hypervector
lvl_hv  input  D  level hypervector
out_valid  output  1  bundled_hv valid
out_ready  input  1  consumer accepts bundled_hv
bundled_hv  output  D  bundled result
busy  output  1  high in every state except IDLE
err  output  1  sticky generator-timeout flag; cleared by next accepted start

Behaviour:
Reset (rst=0, asynchronous):
- State goes to IDLE.
- Counters, feature index k, bundled_hv, gen_seed and gen_scalar are cleared.
- gen_req, feat_ready, out_valid, busy and err all go to 0.

State machine (one transition per clk):
- IDLE: on start=1, latch num_feat, threshold and seed_base; clear all counters and k; clear err. Go to THRESH if num_feat=0, else FETCH.
- FETCH: feat_ready=1. On feat_valid=1:
  - gen_scalar <= feat_level.
  - gen_seed <= seed_base+k (mod 2^11). If that result is 0, use 11'h001 (an LFSR must never be seeded 0).
  - Go to REQ.
- REQ: gen_req=1 for exactly this cycle; clear the wait timer. Go to WAIT.
- WAIT:
  - On hv_valid=1: register xored = pos_hv ^ lvl_hv and go to ACC.
  - Otherwise the timer increments. When the timer reaches TIMEOUT: set err=1, discard the sample (out_valid never asserted) and go to IDLE.
  - hv_valid arriving in the same cycle the timer reaches TIMEOUT counts as success.
- ACC: for each bit i, cnt[i] <= cnt[i]+xored[i], saturating at 2^CNT_W-1; k <= k+1. Go to THRESH if k+1==num_feat, else FETCH.
- THRESH: bundled_hv[i] <= (cnt[i] >= threshold). Go to OUT.
- OUT: out_valid=1. bundled_hv is held stable while out_valid=1 && out_ready=0. When out_valid&out_ready: go to IDLE; bundled_hv keeps its value.

Latency and throughput:
- Each feature takes 4 cycles minimum (FETCH accept, REQ, WAIT with hv_valid on first cycle, ACC).
- From the last ACC: THRESH takes 1 cycle, then out_valid rises the next cycle.

Boundary conditions:
- start while not IDLE: ignored. num_feat, threshold and seed_base changes after start: no effect.
- threshold=0: all bundled bits are 1.
- Counter saturation: a saturated counter stays at max; no wrap.
- hv_valid outside WAIT: ignored. feat_valid outside FETCH: not accepted (feat_ready=0).
- Reset asserted mid-sample: immediate return to IDLE; all partial counts are lost.
- A timed-out sample leaves the counters dirty; they are cleared on the next start.

Test Plan:
- D=8, num_feat=3, threshold=2, generator responds next cycle with xored patterns 0x0F, 0x3C, 0xF0 -> bundled_hv=0x3C. out_valid rises 14 cycles after start accepted. gen_seed per feature = seed_base, +1, +2.
- seed_base=11'h7FF, num_feat=2 -> gen_seed=11'h7FF then 11'h001 (the 0 result is substituted), never 0.
- num_feat=0, threshold=0 -> no gen_req. bundled_hv=all ones; out_valid 2 cycles after start.
- CNT_W=2, num_feat=5, xored all ones each feature, threshold=3 -> counters saturate at 3, bundled_hv all ones, no wrap to 0.
- hv_valid withheld for TIMEOUT cycles -> err=1 and return to IDLE with out_valid never asserted. Next start clears err and completes normally.
- Backpressure and reset:
  - out_ready held 0 for 10 cycles -> bundled_hv stable, out_valid high; accepted on the cycle out_ready=1.
  - rst pulsed low during WAIT -> all outputs 0 immediately.
